// File: rtl/hazard_unit_param.sv
// Pipeline hazard unit: load-use stall with configurable latency, registered branch flush of
// configurable depth, and EX-stage operand forwarding selects from MEM and WB.
module hazard_unit_param #(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned LOAD_LATENCY = 1,
  parameter int unsigned FLUSH_DEPTH  = 1,
  parameter int unsigned ZERO_REG     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_taken,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  output logic              stall,
  output logic              flush,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b
);

  localparam logic [3:0] StallReload = 4'(LOAD_LATENCY - 1);
  localparam logic [2:0] FlushReload = 3'(FLUSH_DEPTH);

  function automatic logic reg_match(input logic [REG_AW-1:0] x, input logic [REG_AW-1:0] y);
    return (x == y) && !((ZERO_REG != 0) && (x == '0));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic              mem_w,
                                         input logic [REG_AW-1:0] mem_r,
                                         input logic              wb_w,
                                         input logic [REG_AW-1:0] wb_r,
                                         input logic [REG_AW-1:0] src);
    if (mem_w && reg_match(mem_r, src)) begin
      return 2'b01;
    end else if (wb_w && reg_match(wb_r, src)) begin
      return 2'b10;
    end
    return 2'b00;
  endfunction

  logic       hz;
  logic [3:0] scnt_q, scnt_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic       flush_q, flush_d;

  always_comb begin
    hz = ex_mem_read && (reg_match(ex_rd, id_rs) || (id_uses_rt && reg_match(ex_rd, id_rt)));
  end

  // Flush window: a new branch reloads the full depth rather than stacking.
  always_comb begin
    fcnt_d  = '0;
    flush_d = 1'b0;
    if (branch_taken) begin
      fcnt_d  = FlushReload;
      flush_d = 1'b1;
    end else if (fcnt_q > 3'd1) begin
      fcnt_d  = fcnt_q - 3'd1;
      flush_d = 1'b1;
    end
  end

  // The first stall cycle comes from hz directly, so the counter covers the remaining ones.
  always_comb begin
    scnt_d = '0;
    if (flush_q) begin
      scnt_d = '0;
    end else if (scnt_q != '0) begin
      scnt_d = scnt_q - 4'd1;
    end else if (hz) begin
      scnt_d = StallReload;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scnt_q  <= '0;
      fcnt_q  <= '0;
      flush_q <= 1'b0;
    end else begin
      scnt_q  <= scnt_d;
      fcnt_q  <= fcnt_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    stall     = !rst && !flush_q && (hz || (scnt_q != '0));
    flush     = flush_q;
    forward_a = fwd_sel(mem_reg_write, mem_rd, wb_reg_write, wb_rd, ex_rs);
    forward_b = fwd_sel(mem_reg_write, mem_rd, wb_reg_write, wb_rd, ex_rt);
  end

endmodule

// File: tb/tb_hazard_unit_param.sv
// Bench for hazard_unit_param: two instances (latency 1 / depth 1 and latency 3 / depth 2)
// share stimulus; each driven cycle queues its expected outputs, checked at the falling edge.
module tb_hazard_unit_param;

  typedef struct {
    logic       rst;
    logic       br;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       uses_rt;
    logic       ex_mr;
    logic [4:0] ex_rd;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic       mem_w;
    logic [4:0] mem_rd;
    logic       wb_w;
    logic [4:0] wb_rd;
    logic       s1;
    logic       s3;
    logic       f1;
    logic       f3;
    logic [1:0] fa;
    logic [1:0] fb;
    string      nm;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       branch_taken;
  logic [4:0] id_rs, id_rt, ex_rd, ex_rs, ex_rt, mem_rd, wb_rd;
  logic       id_uses_rt, ex_mem_read, mem_reg_write, wb_reg_write;
  logic       stall1, flush1, stall3, flush3;
  logic [1:0] fa1, fb1, fa3, fb3;

  int   checks = 0;
  int   errors = 0;
  vec_t exp_q[$];
  vec_t cur;
  vec_t tbl[$];

  hazard_unit_param #(
    .REG_AW(5), .LOAD_LATENCY(1), .FLUSH_DEPTH(1), .ZERO_REG(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .stall(stall1), .flush(flush1),
    .forward_a(fa1), .forward_b(fb1)
  );

  hazard_unit_param #(
    .REG_AW(5), .LOAD_LATENCY(3), .FLUSH_DEPTH(2), .ZERO_REG(1)
  ) u_dut3 (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .stall(stall3), .flush(flush3),
    .forward_a(fa3), .forward_b(fb3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string what, input string nm, input logic [1:0] act,
                     input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s got %b want %b", nm, what, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      chk("stall_l1", cur.nm, {1'b0, stall1}, {1'b0, cur.s1});
      chk("stall_l3", cur.nm, {1'b0, stall3}, {1'b0, cur.s3});
      chk("flush_d1", cur.nm, {1'b0, flush1}, {1'b0, cur.f1});
      chk("flush_d2", cur.nm, {1'b0, flush3}, {1'b0, cur.f3});
      chk("fwd_a_1", cur.nm, fa1, cur.fa);
      chk("fwd_b_1", cur.nm, fb1, cur.fb);
      chk("fwd_a_3", cur.nm, fa3, cur.fa);
      chk("fwd_b_3", cur.nm, fb3, cur.fb);
    end
  end

  function automatic vec_t base(input string nm);
    vec_t v;
    v.rst = 1'b0; v.br = 1'b0; v.id_rs = '0; v.id_rt = '0; v.uses_rt = 1'b0;
    v.ex_mr = 1'b0; v.ex_rd = '0; v.ex_rs = '0; v.ex_rt = '0;
    v.mem_w = 1'b0; v.mem_rd = '0; v.wb_w = 1'b0; v.wb_rd = '0;
    v.s1 = 1'b0; v.s3 = 1'b0; v.f1 = 1'b0; v.f3 = 1'b0; v.fa = 2'b00; v.fb = 2'b00;
    v.nm = nm;
    return v;
  endfunction

  // Control-path vector; h selects a load-use hazard on rt (ex_rd = id_rt = 7).
  function automatic vec_t mk(input string nm, input logic r, input logic br, input logic h,
                              input logic s1, input logic s3, input logic f1, input logic f3);
    vec_t v;
    v = base(nm);
    v.rst = r;
    v.br  = br;
    if (h) begin
      v.ex_mr = 1'b1; v.ex_rd = 5'd7; v.id_rt = 5'd7; v.uses_rt = 1'b1; v.id_rs = 5'd2;
    end
    v.s1 = s1; v.s3 = s3; v.f1 = f1; v.f3 = f3;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    rst = v.rst; branch_taken = v.br; id_rs = v.id_rs; id_rt = v.id_rt;
    id_uses_rt = v.uses_rt; ex_mem_read = v.ex_mr; ex_rd = v.ex_rd; ex_rs = v.ex_rs;
    ex_rt = v.ex_rt; mem_reg_write = v.mem_w; mem_rd = v.mem_rd;
    wb_reg_write = v.wb_w; wb_rd = v.wb_rd;
    exp_q.push_back(v);
  endtask

  initial begin
    vec_t t;
    rst = 1'b1; branch_taken = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_rd = '0; ex_rs = '0; ex_rt = '0;
    mem_reg_write = 1'b0; mem_rd = '0; wb_reg_write = 1'b0; wb_rd = '0;

    t = base("lu_rs");     t.ex_mr = 1; t.ex_rd = 5; t.id_rs = 5; t.s1 = 1; t.s3 = 1;
    tbl.push_back(t);
    t = base("lu_rt");     t.ex_mr = 1; t.ex_rd = 7; t.id_rt = 7; t.uses_rt = 1; t.id_rs = 2;
    t.s1 = 1; t.s3 = 1;    tbl.push_back(t);
    t = base("lu_rt_off"); t.ex_mr = 1; t.ex_rd = 7; t.id_rt = 7; t.id_rs = 2;
    tbl.push_back(t);
    t = base("lu_zero");   t.ex_mr = 1; t.ex_rd = 0; t.id_rs = 0; t.id_rt = 0; t.uses_rt = 1;
    tbl.push_back(t);
    t = base("no_load");   t.ex_rd = 5; t.id_rs = 5;                         tbl.push_back(t);
    t = base("lu_other");  t.ex_mr = 1; t.ex_rd = 6; t.id_rs = 5; t.id_rt = 7; t.uses_rt = 1;
    tbl.push_back(t);
    t = base("fwd_both");  t.mem_w = 1; t.wb_w = 1; t.mem_rd = 3; t.wb_rd = 3; t.ex_rs = 3;
    t.fa = 2'b01;          tbl.push_back(t);
    t = base("fwd_wb");    t.wb_w = 1; t.mem_rd = 3; t.wb_rd = 3; t.ex_rs = 3; t.fa = 2'b10;
    tbl.push_back(t);
    t = base("fwd_zero");  t.mem_w = 1; t.wb_w = 1; t.mem_rd = 0; t.wb_rd = 0;
    tbl.push_back(t);
    t = base("fwd_b_mem"); t.mem_w = 1; t.wb_w = 1; t.mem_rd = 9; t.wb_rd = 9; t.ex_rt = 9;
    t.ex_rs = 4; t.fb = 2'b01; tbl.push_back(t);
    t = base("fwd_mix");   t.mem_w = 1; t.wb_w = 1; t.mem_rd = 4; t.wb_rd = 6; t.ex_rs = 4;
    t.ex_rt = 6; t.fa = 2'b01; t.fb = 2'b10; tbl.push_back(t);
    t = base("fwd_nowr");  t.mem_rd = 3; t.wb_rd = 3; t.ex_rs = 3; t.ex_rt = 3;
    tbl.push_back(t);

    repeat (2) @(posedge clk);
    apply(mk("reset", 1, 0, 0, 0, 0, 0, 0));

    // Each table vector is followed by a reset cycle so stall state never carries over.
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      apply(mk("rst_gap", 1, 0, 0, 0, 0, 0, 0));
    end

    apply(mk("a_haz",   0, 0, 1, 1, 1, 0, 0));
    apply(mk("a_s2",    0, 0, 0, 0, 1, 0, 0));
    apply(mk("a_s3",    0, 0, 0, 0, 1, 0, 0));
    apply(mk("a_end",   0, 0, 0, 0, 0, 0, 0));

    apply(mk("b_haz",   0, 0, 1, 1, 1, 0, 0));
    apply(mk("b_hold",  0, 0, 1, 1, 1, 0, 0));
    apply(mk("b_s3",    0, 0, 0, 0, 1, 0, 0));
    apply(mk("b_end",   0, 0, 0, 0, 0, 0, 0));

    apply(mk("c_br",    0, 1, 0, 0, 0, 0, 0));
    apply(mk("c_f1",    0, 0, 0, 0, 0, 1, 1));
    apply(mk("c_f2",    0, 0, 0, 0, 0, 0, 1));
    apply(mk("c_end",   0, 0, 0, 0, 0, 0, 0));

    apply(mk("d_br",    0, 1, 0, 0, 0, 0, 0));
    apply(mk("d_br2",   0, 1, 0, 0, 0, 1, 1));
    apply(mk("d_f2",    0, 0, 0, 0, 0, 1, 1));
    apply(mk("d_f3",    0, 0, 0, 0, 0, 0, 1));
    apply(mk("d_end",   0, 0, 0, 0, 0, 0, 0));

    apply(mk("e_br",    0, 1, 0, 0, 0, 0, 0));
    apply(mk("e_hzf",   0, 0, 1, 0, 0, 1, 1));
    apply(mk("e_hzf3",  0, 0, 1, 1, 0, 0, 1));
    apply(mk("e_clr",   0, 0, 0, 0, 0, 0, 0));
    apply(mk("e_end",   0, 0, 0, 0, 0, 0, 0));

    apply(mk("f_haz",   0, 0, 1, 1, 1, 0, 0));
    apply(mk("f_rst",   1, 0, 1, 0, 0, 0, 0));
    apply(mk("f_after", 0, 0, 0, 0, 0, 0, 0));
    apply(mk("f_end",   0, 0, 0, 0, 0, 0, 0));

    apply(mk("g_br",    0, 1, 0, 0, 0, 0, 0));
    apply(mk("g_rst",   1, 1, 0, 0, 0, 1, 1));
    apply(mk("g_after", 0, 0, 0, 0, 0, 0, 0));
    apply(mk("g_end",   0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit_param.md
Name: hazard_unit_param

Overview:
- Parametrised next-generation hazard unit for the pipelined CPU.
- Detects load-use hazards in ID against a load in EX and stalls for a configurable number of cycles, covering multi-cycle memory.
- Generates registered branch flushes of configurable depth.
- Produces EX-stage operand forwarding selects from the MEM and WB stages.
- Sits beside the ID/EX pipeline registers; drives PC/IF-ID hold, ID/EX bubble, flush and the EX operand muxes.

Parameters:
- REG_AW, 5: register address width.
- LOAD_LATENCY, 1: stall cycles per load-use hazard, range 1..15. A value of 1 gives the classic single bubble.
- FLUSH_DEPTH, 1: cycles `flush` is held after a taken branch, range 1..7.
- ZERO_REG, 1: when 1, register 0 never creates a hazard and is never forwarded.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- branch_taken  in  1  branch resolved taken this cycle.
- id_rs  in  REG_AW  ID-stage source register 1.
- id_rt  in  REG_AW  ID-stage source register 2.
- id_uses_rt  in  1  ID instruction actually reads rt.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rd  in  REG_AW  EX destination register.
- ex_rs  in  REG_AW  EX source register 1, used for forwarding.
- ex_rt  in  REG_AW  EX source register 2, used for forwarding.
- mem_reg_write  in  1  MEM instruction writes the register file.
- mem_rd  in  REG_AW  MEM destination register.
- wb_reg_write  in  1  WB instruction writes the register file.
- wb_rd  in  REG_AW  WB destination register.
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EX.
- flush  out  1  squash IF/ID (and ID/EX) contents.
- forward_a  out  2  EX operand A select: 00 register file, 01 MEM result, 10 WB result.
- forward_b  out  2  EX operand B select; same encoding as forward_a.

Behaviour:
Reset
- Synchronous, active-high `rst`; `clk` is the only clock.
- While `rst` is high at a rising edge: stall counter scnt=0, flush counter fcnt=0, flush=0.
- stall is 0 throughout reset.
- Reset mid-stall or mid-flush aborts it immediately; outputs are 0 from the first cycle after the reset edge.

Name matching
- match(x,y) = (x==y) && !(ZERO_REG && x==0).

Load-use detection (combinational)
- hz = ex_mem_read && (match(ex_rd,id_rs) || (id_uses_rt && match(ex_rd,id_rt))).

Stall
- stall = !flush && (hz || scnt!=0).
- Rising edge with scnt==0, hz=1, flush=0: scnt <= LOAD_LATENCY-1.
- Rising edge with scnt!=0: scnt <= scnt-1.
- A new hz while scnt!=0 does not reload the counter.
- Result: exactly LOAD_LATENCY consecutive stall cycles per hazard. For LOAD_LATENCY=1, stall is purely combinational, as in the previous generation.
- scnt width is 4 bits.

Flush (registered)
- Rising edge with branch_taken=1: fcnt <= FLUSH_DEPTH and flush <= 1.
- Rising edge with branch_taken=0 and fcnt>1: fcnt <= fcnt-1 and flush stays 1.
- Rising edge with branch_taken=0 and fcnt==1: fcnt <= 0 and flush <= 0.
- Latency: flush rises on the edge that samples branch_taken and stays high for exactly FLUSH_DEPTH cycles.
- A branch_taken during an active flush reloads fcnt to FLUSH_DEPTH; the flush window is extended, not stacked.
- Flush has priority over stall: while flush=1, stall=0, and on that edge scnt <= 0. The dependent instruction is squashed.

Forwarding (combinational)
- forward_a = 01 if mem_reg_write && match(mem_rd,ex_rs).
- Otherwise forward_a = 10 if wb_reg_write && match(wb_rd,ex_rs).
- Otherwise forward_a = 00.
- forward_b uses the same rule with ex_rt.
- MEM has priority over WB when both match.
- Encoding 11 is never produced.

Widths
- All compares are REG_AW bits.
- No X on outputs after reset, regardless of input state.

Test Plan:
1. LOAD_LATENCY=1: ex_mem_read=1, ex_rd=5, id_rs=5 for one cycle -> stall=1 in that cycle only; scnt stays 0.
2. LOAD_LATENCY=3: hazard on id_rt=7 with id_uses_rt=1 -> stall high 3 consecutive cycles, then 0. Same stimulus with id_uses_rt=0 -> stall=0. ex_rd=0 with ZERO_REG=1 -> stall=0.
3. FLUSH_DEPTH=2: branch_taken pulsed at edge N -> flush=1 during cycles N..N+1, then 0. Second branch_taken at edge N+1 -> flush held through N+2.
4. Load-use hazard coincident with flush active -> stall=0 and the counter is cleared; after the flush ends with no hazard, stall=0.
5. Forwarding: mem_rd=wb_rd=ex_rs=3, both reg_write=1 -> forward_a=01. With mem_reg_write=0 -> 10. ex_rt=0 with wb_rd=0 -> forward_b=00.
6. Assert rst during the 2nd cycle of a 3-cycle stall and during an active flush -> after the reset edge, stall=0, flush=0, and no residual stall once rst drops.
